led_anim_sequencer: RTL and testbench

Frame sequencer for the LED animation pattern path: generates the 5-bit step index that drives the 7-segment pattern decoder, advancing one step per programmable frame period. Supports loop, one-shot and ping-pong playback with start/stop/pause control, and reports progress to the top-level control logic. Sits between the board's button/switch front end and the pattern decoder.

---
 rtl/led_anim_sequencer.sv | 131 +++++++++++++
 tb/tb_led_anim_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_anim_sequencer.sv
// rtl/led_anim_sequencer.sv - frame step sequencer for the LED pattern decoder (loop/one-shot/ping-pong).
// Optional ping-pong playback is built only when LED_ANIM_PINGPONG_EN is defined.
module led_anim_sequencer #(
  parameter int PRESCALE  = 8,
  parameter int DIV_W     = 24,
  parameter int LAST_STEP = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [2:0] speed,
  output logic [4:0] step,
  output logic       step_adv,
  output logic       dir,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [4:0]       LAST = 5'(LAST_STEP);
  localparam logic [DIV_W-1:0] PRE  = DIV_W'(PRESCALE);

  logic [1:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] period;
  logic [2:0]       speed_l;
  logic             oneshot_l;
  logic [4:0]       loop_next;

`ifdef LED_ANIM_PINGPONG_EN
  logic pp_l;
  logic dir_q;
  assign dir = dir_q;
`else
  assign dir = 1'b0;
`endif

  // High speed settings can shift the period to zero; clamp to one cycle per frame.
  assign shifted   = PRE >> speed_l;
  assign period    = (shifted == '0) ? DIV_W'(1) : shifted;
  assign busy      = (state != S_IDLE);
  assign loop_next = (step == LAST) ? 5'd0 : step + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step      <= 5'd0;
      step_adv  <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      speed_l   <= 3'd0;
      oneshot_l <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
      pp_l      <= 1'b0;
      dir_q     <= 1'b0;
`endif
    end else begin
      step_adv <= 1'b0;
      done     <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        step  <= 5'd0;
        cnt   <= '0;
`ifdef LED_ANIM_PINGPONG_EN
        dir_q <= 1'b0;
`endif
      end else if (start) begin
        state     <= S_RUN;
        step      <= 5'd0;
        cnt       <= '0;
        speed_l   <= speed;
        oneshot_l <= (mode == 2'b01);
`ifdef LED_ANIM_PINGPONG_EN
        pp_l      <= (mode == 2'b10);
        dir_q     <= 1'b0;
`endif
      end else if (state != S_IDLE) begin
        // The release edge already counts, so a pause stretches the period by exactly its length.
        if (pause) begin
          state <= S_PAUSE;
        end else begin
          state <= S_RUN;
          if (cnt != period - DIV_W'(1)) begin
            cnt <= cnt + DIV_W'(1);
          end else begin
            cnt <= '0;
            if (oneshot_l && step == LAST) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              step_adv <= 1'b1;
`ifdef LED_ANIM_PINGPONG_EN
              if (pp_l) begin
                if (LAST == 5'd0) begin
                  step <= 5'd0;
                end else if (!dir_q) begin
                  if (step == LAST) begin
                    dir_q <= 1'b1;
                    step  <= LAST - 5'd1;
                  end else begin
                    step <= step + 5'd1;
                  end
                end else begin
                  if (step == 5'd0) begin
                    dir_q <= 1'b0;
                    step  <= 5'd1;
                  end else begin
                    step <= step - 5'd1;
                  end
                end
              end else begin
                step <= loop_next;
              end
`else
              step <= loop_next;
`endif
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_anim_sequencer.sv
// tb/tb_led_anim_sequencer.sv - self-checking bench for led_anim_sequencer (PRESCALE 8, LAST_STEP 3).
// Honours LED_ANIM_PINGPONG_EN to select the expected ping-pong or loop behaviour.
module tb_led_anim_sequencer;

  localparam int PRE = 8;
  localparam int L   = 3;
`ifdef LED_ANIM_PINGPONG_EN
  localparam bit PP_EN = 1'b1;
`else
  localparam bit PP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] speed = 3'd0;
  logic [4:0] step;
  logic       step_adv, dir, busy, done;

  int checks = 0;
  int failures = 0;

  led_anim_sequencer #(.PRESCALE(PRE), .DIV_W(24), .LAST_STEP(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .speed(speed), .step(step), .step_adv(step_adv),
    .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: counts unpaused cycles since start and derives the frame from that count.
  bit m_busy, m_adv, m_done, m_dir, m_os, m_pp;
  int m_step, m_k, m_p;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_adv = 0; m_done = 0; m_dir = 0; m_step = 0; m_k = 0; m_p = 1;
    m_os = 0; m_pp = 0;
  endtask

  task automatic model_edge();
    int n, t;
    m_adv = 0;
    m_done = 0;
    if (stop) begin
      m_busy = 0; m_step = 0; m_dir = 0;
    end else if (start) begin
      m_busy = 1; m_step = 0; m_dir = 0; m_k = 0;
      m_p = (PRE >> speed) == 0 ? 1 : (PRE >> speed);
      m_os = (mode == 2'b01);
      m_pp = PP_EN && (mode == 2'b10);
    end else if (m_busy && !pause) begin
      m_k++;
      n = m_k / m_p;
      m_adv = (m_k % m_p == 0);
      if (m_os) begin
        if (n > L) begin
          m_busy = 0; m_done = 1; m_adv = 0; m_step = L;
        end else begin
          m_step = n;
        end
      end else if (m_pp) begin
        if (L == 0) begin
          m_step = 0; m_dir = 0;
        end else begin
          t = n % (2 * L);
          m_step = (t <= L) ? t : 2 * L - t;
          m_dir = (n > 0) && (t == 0 || t > L);
        end
      end else begin
        m_step = n % (L + 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_step", int'(step), m_step);
    chk("model_adv", int'(step_adv), int'(m_adv));
    chk("model_dir", int'(dir), int'(m_dir));
    chk("model_busy", int'(busy), int'(m_busy));
    chk("model_done", int'(done), int'(m_done));
  endtask

  task automatic drive(input logic s, input logic st, input logic p, input logic [1:0] m,
                       input logic [2:0] sp);
    start = s; stop = st; pause = p; mode = m; speed = sp;
  endtask

  typedef struct {
    logic       start, stop, pause;
    logic [1:0] mode;
    logic [2:0] speed;
    logic [4:0] step;
    logic       adv, busy, done;
  } vec_t;

  vec_t tbl[16];
  int   pp_step[8];
  int   pp_dir[8];

  initial begin
    // Loop at period 2, stop, then one-shot at period 1.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 3'd2, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd2, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 5'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd2, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 1'b0, 1'b0, 1'b0};
`ifdef LED_ANIM_PINGPONG_EN
    pp_step = '{1, 2, 3, 2, 1, 0, 1, 2};
    pp_dir  = '{0, 0, 0, 1, 1, 1, 0, 0};
`else
    pp_step = '{1, 2, 3, 0, 1, 2, 3, 0};
    pp_dir  = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    model_reset();
    #12;
    chk("reset_step", int'(step), 0);
    chk("reset_adv", int'(step_adv), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].mode, tbl[i].speed);
      tick();
      chk($sformatf("tbl%0d_step", i), int'(step), int'(tbl[i].step));
      chk($sformatf("tbl%0d_adv", i), int'(step_adv), int'(tbl[i].adv));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].done));
    end

    // Mode 10 at period 1: ping-pong when built in, loop otherwise.
    drive(1'b1, 1'b0, 1'b0, 2'd2, 3'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("pp%0d_step", i), int'(step), pp_step[i]);
      chk($sformatf("pp%0d_dir", i), int'(dir), pp_dir[i]);
      chk($sformatf("pp%0d_adv", i), int'(step_adv), 1);
    end

    // Speed 7 clamps the period to one cycle.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd7);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("spd7_%0d_adv", i), int'(step_adv), 1);
      chk($sformatf("spd7_%0d_step", i), int'(step), (i + 1) % (L + 1));
    end

    // Pause for 10 cycles at prescaler 2 of step 1 (period 4).
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    repeat (4) tick();
    chk("pause_pre_step", int'(step), 1);
    repeat (2) tick();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_hold_step", int'(step), 1);
      chk("pause_hold_busy", int'(busy), 1);
    end
    pause = 1'b0;
    tick();
    chk("pause_rel1_step", int'(step), 1);
    tick();
    chk("pause_rel2_step", int'(step), 2);
    chk("pause_rel2_adv", int'(step_adv), 1);

    // stop and start together: stop wins.
    repeat (3) tick();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd1);
    tick();
    chk("stopstart_step", int'(step), 0);
    chk("stopstart_busy", int'(busy), 0);
    chk("stopstart_adv", int'(step_adv), 0);

    // Asynchronous reset mid-run.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
    repeat (2) tick();
    chk("prerst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_step", int'(step), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_adv", int'(step_adv), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      mode  = 2'($urandom_range(0, 3));
      speed = 3'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
